// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - operand/result handshake bundle for alu_pipe
//
// Purpose: groups the operand beat (valid_i/ready_o/op_i/a_i/b_i) and the
//          result beat (valid_o/ready_i/result_o/zero_o/ovf_o) of alu_pipe.
// Ports (signals):
//    valid_i, ready_o, op_i[2:0], a_i[NB_BITS-1:0], b_i[NB_BITS-1:0]
//    valid_o, ready_i, result_o[NB_BITS:0], zero_o, ovf_o
// Modports: slave = ALU side, master = the block driving operands and
//           accepting results.
interface alu_pipe_if #(
   parameter int NB_BITS = 32
);
   logic               valid_i;
   logic               ready_o;
   logic [2:0]         op_i;
   logic [NB_BITS-1:0] a_i;
   logic [NB_BITS-1:0] b_i;
   logic               valid_o;
   logic               ready_i;
   logic [NB_BITS:0]   result_o;
   logic               zero_o;
   logic               ovf_o;

   modport slave (
      input  valid_i, op_i, a_i, b_i, ready_i,
      output ready_o, valid_o, result_o, zero_o, ovf_o
   );

   modport master (
      output valid_i, op_i, a_i, b_i, ready_i,
      input  ready_o, valid_o, result_o, zero_o, ovf_o
   );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready pipelined ALU
//
// Purpose: S1 registers operands and opcode, S2 registers the result and
//          flags. One beat per cycle when the downstream keeps ready_i high.
// Ports:
//    clock_i   : clock, rising edge
//    resetb_i  : asynchronous active-low reset
//    bus       : alu_pipe_if.slave (operand beat in, result beat out)
// Optional feature: define ALU_SAT_EN to turn opcode 111 into a signed
//    saturating add; otherwise opcode 111 is a plain ADD.
module alu_pipe #(
   parameter int NB_BITS = 32,
   parameter int SH_BITS = $clog2(NB_BITS)
) (
   input  logic        clock_i,
   input  logic        resetb_i,
   alu_pipe_if.slave   bus
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_SAT = 3'b111;

   localparam logic [NB_BITS-1:0] SAT_MAX = {1'b0, {(NB_BITS-1){1'b1}}};
   localparam logic [NB_BITS-1:0] SAT_MIN = {1'b1, {(NB_BITS-1){1'b0}}};

   // stage 1
   logic               s1_valid;
   logic [2:0]         s1_op;
   logic [NB_BITS-1:0] s1_a;
   logic [NB_BITS-1:0] s1_b;

   // stage 2
   logic               s2_valid;
   logic [NB_BITS:0]   s2_result;
   logic               s2_zero;
   logic               s2_ovf;

   logic               accept;
   logic               consume;
   logic               s2_load;

   logic [NB_BITS:0]   sum_w;
   logic [NB_BITS:0]   diff_w;
   logic               add_ovf;
   logic               sub_ovf;
   logic [NB_BITS:0]   alu_res;
   logic               alu_ovf;

   // S1 can take a beat if it is empty, or if its content moves to S2 this
   // cycle (S2 empty or S2 being drained).
   assign bus.ready_o = !s1_valid || !s2_valid || bus.ready_i;
   assign accept      = bus.valid_i && bus.ready_o;
   assign consume     = s2_valid && bus.ready_i;
   assign s2_load     = s1_valid && (!s2_valid || bus.ready_i);

   assign bus.valid_o  = s2_valid;
   assign bus.result_o = s2_result;
   assign bus.zero_o   = s2_zero;
   assign bus.ovf_o    = s2_ovf;

   // One extra bit captures carry out; for subtraction it is the unsigned
   // borrow (a < b).
   assign sum_w  = {1'b0, s1_a} + {1'b0, s1_b};
   assign diff_w = {1'b0, s1_a} - {1'b0, s1_b};

   // Signed overflow: add overflows when operands share a sign the result
   // lacks; subtract when operand signs differ and result sign flips from a.
   assign add_ovf = (s1_a[NB_BITS-1] == s1_b[NB_BITS-1]) &&
                    (sum_w[NB_BITS-1] != s1_a[NB_BITS-1]);
   assign sub_ovf = (s1_a[NB_BITS-1] != s1_b[NB_BITS-1]) &&
                    (diff_w[NB_BITS-1] != s1_a[NB_BITS-1]);

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (s1_op)
         OP_ADD: begin
            alu_res = sum_w;
            alu_ovf = add_ovf;
         end
         OP_SUB: begin
            alu_res = diff_w;
            alu_ovf = sub_ovf;
         end
         OP_AND: alu_res = {1'b0, s1_a & s1_b};
         OP_OR:  alu_res = {1'b0, s1_a | s1_b};
         OP_XOR: alu_res = {1'b0, s1_a ^ s1_b};
         OP_SLL: alu_res = {1'b0, s1_a << s1_b[SH_BITS-1:0]};
         OP_SRL: alu_res = {1'b0, s1_a >> s1_b[SH_BITS-1:0]};
`ifdef ALU_SAT_EN
         OP_SAT: begin
            // Signed result: the carry bit carries no meaning, kept at 0.
            alu_ovf = add_ovf;
            if (add_ovf)
               alu_res = {1'b0, (s1_a[NB_BITS-1] ? SAT_MIN : SAT_MAX)};
            else
               alu_res = {1'b0, sum_w[NB_BITS-1:0]};
         end
`else
         OP_SAT: begin
            alu_res = sum_w;
            alu_ovf = add_ovf;
         end
`endif
      endcase
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         s1_valid  <= 1'b0;
         s1_op     <= '0;
         s1_a      <= '0;
         s1_b      <= '0;
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_zero   <= 1'b0;
         s2_ovf    <= 1'b0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= bus.op_i;
            s1_a     <= bus.a_i;
            s1_b     <= bus.b_i;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end

         // S2 holds its content while stalled so outputs stay stable.
         if (s2_load) begin
            s2_valid  <= 1'b1;
            s2_result <= alu_res;
            s2_zero   <= (alu_res[NB_BITS-1:0] == '0);
            s2_ovf    <= alu_ovf;
         end else if (consume) begin
            s2_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter NB_BITS, default 32, operand width; legal values 8..64.
REQ-002 Parameter SH_BITS, default $clog2(NB_BITS), width of the shift amount taken from b_i.
REQ-003 clock_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 resetb_i  input  1  reset; asynchronous, active-low.
REQ-005 valid_i  input  1  operand/opcode beat present.
REQ-006 ready_o  output  1  block can accept a beat this cycle.
REQ-007 op_i  input  3  opcode.
REQ-008 a_i  input  NB_BITS  operand A.
REQ-009 b_i  input  NB_BITS  operand B.
REQ-010 valid_o  output  1  result beat present.
REQ-011 ready_i  input  1  downstream accepts the result beat.
REQ-012 result_o  output  NB_BITS+1  result; bit NB_BITS is carry/borrow.
REQ-013 zero_o  output  1  result_o[NB_BITS-1:0] == 0.
REQ-014 ovf_o  output  1  signed overflow flag.

Function
REQ-015 A beat SHALL be accepted on a rising edge where valid_i && ready_o.
REQ-016 A result SHALL be consumed on a rising edge where valid_o && ready_i.
REQ-017 Pipeline has two register stages: S1 (operands and opcode) and S2 (result and flags).
REQ-018 S2 SHALL load when S1 is valid and (S2 is empty or S2 is consumed in the same cycle).
REQ-019 ready_o SHALL equal !S1_valid || !S2_valid || ready_i; this ready_o is combinational.
REQ-020 Latency: a beat accepted at edge k SHALL appear on valid_o after edge k+1, with no stall.
REQ-021 Throughput is one beat per cycle while ready_i stays high.
REQ-022 While valid_o && !ready_i, result_o, zero_o and ovf_o SHALL hold stable.
REQ-023 Simultaneous accept and consume in the same cycle SHALL lose no beat and duplicate no beat.
REQ-024 Opcode 000 ADD: result_o = {carry, a+b}; ovf_o = signed overflow.
REQ-025 Opcode 001 SUB: result_o = {borrow, a-b}, with borrow = (a<b unsigned); ovf_o = signed overflow.
REQ-026 Opcodes 010 AND, 011 OR and 100 XOR produce bitwise results with MSB 0 and ovf_o 0.
REQ-027 Opcodes 101 SLL and 110 SRL shift a by b[SH_BITS-1:0] with zero fill; MSB 0; ovf_o 0.
REQ-028 Opcode 111 is governed by REQ-033/REQ-034.
REQ-029 zero_o SHALL ignore bit NB_BITS.

Reset
REQ-030 While resetb_i is low, valid_o, S1_valid, S2_valid, result_o, zero_o and ovf_o SHALL be 0.
REQ-031 ready_o SHALL be 1 during and after reset.
REQ-032 Reset asserted mid-stream SHALL discard all in-flight beats; the first beat after release SHALL have latency per REQ-020.

Configuration
REQ-033 With macro ALU_SAT_EN defined, opcode 111 SHALL be a signed saturating add: on overflow, result is 0x7F..F or 0x80..0, ovf_o = 1 and MSB 0.
REQ-034 Without ALU_SAT_EN, opcode 111 SHALL behave exactly as opcode 000 ADD.

Verification (NB_BITS=32 unless stated)
REQ-035 ADD a=0xFFFFFFFF, b=0x00000001 -> result_o=0x1_00000000, zero_o=1, ovf_o=0, valid_o after 2 edges.
REQ-036 SUB a=0x80000000, b=0x00000001 -> result_o=0x0_7FFFFFFF, ovf_o=1; SUB a=1, b=2 -> result_o=0x1_FFFFFFFF.
REQ-037 Back-to-back beats with ready_i low for 3 cycles -> ready_o drops after 2 beats held; all beats delivered in order, no loss.
REQ-038 Op 111, a=0x7FFFFFFF, b=1 -> with ALU_SAT_EN: 0x0_7FFFFFFF, ovf_o=1; without it: 0x0_80000000, ovf_o=1.
REQ-039 SLL a=1, b=31 -> 0x0_80000000; SRL a=0x80000000, b=0x20 (b[4:0]=0) -> 0x0_80000000.
REQ-040 Assert resetb_i low asynchronously with both stages full -> valid_o=0 immediately; no stale beat after release.
